// File: rtl/trisc_pkg.sv
// rtl/trisc_pkg.sv - shared loader state encoding and key idle level
package trisc_pkg;
  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT,
    W_LO,
    W_HI,
    A_LO,
    A_HI,
    FIN
  } load_state_t;

  // Key-level pins (ClockIn, ClearAddGen, RW) rest high; the active level is 0.
  localparam logic KEY_IDLE = 1'b1;
endpackage

// File: rtl/trisc_prog_loader_if.sv
// rtl/trisc_prog_loader_if.sv - program byte stream between the source and the loader
interface trisc_prog_loader_if #(
  parameter int DATA_W = 8
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/trisc_pulse_timer.sv
// rtl/trisc_pulse_timer.sv - loadable down-counter timing the loader phases
module trisc_pulse_timer #(
  parameter int W = 3
) (
  input  logic         SysClock,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;

  always_ff @(posedge SysClock or negedge Reset) begin
    if (!Reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Loading N-1 on phase entry makes the phase last N cycles.
  assign done = (cnt == '0);
endmodule

// File: rtl/trisc_prog_loader.sv
// rtl/trisc_prog_loader.sv - streams program bytes into the TRISC RAM via its key-level program pins
module trisc_prog_loader
  import trisc_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int PULSE_W = 4,
  parameter int RST_W   = 2
) (
  input  logic               SysClock,
  input  logic               Reset,
  input  logic               Start,
  trisc_prog_loader_if.slave prog,
  output logic               Mode,
  output logic               ClockIn,
  output logic               ClearAddGen,
  output logic               RW,
  output logic [DATA_W-1:0]  DataIn,
  output logic               CpuReset,
  output logic               Busy,
  output logic               Done,
  output logic               Overflow,
  output logic [4:0]         Count
);
  localparam int TMAX = (PULSE_W > RST_W) ? PULSE_W : RST_W;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_W - 1);
  localparam logic [TW-1:0] RST_LD   = TW'(RST_W - 1);

  load_state_t   state, state_n;
  logic          ph_done, hs, full, last_q, tmr_load;
  logic [TW-1:0] tmr_val;

  assign prog.s_ready = (state == WAIT);
  assign hs           = prog.s_valid && (state == WAIT);
  assign full         = (Count == 5'(DEPTH));
  assign tmr_load     = (state_n != state);
  assign tmr_val      = (state_n == FIN) ? RST_LD : PULSE_LD;

  trisc_pulse_timer #(.W(TW)) u_timer (
    .SysClock (SysClock),
    .Reset    (Reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (ph_done)
  );

  always_ff @(posedge SysClock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (Start) state_n = CLEAR;
      CLEAR: if (ph_done) state_n = WAIT;
      // Once the RAM is full, bytes are drained without pulses until s_last.
      WAIT: begin
        if (hs) begin
          if (!full)              state_n = W_LO;
          else if (prog.s_last)   state_n = FIN;
        end
      end
      W_LO:  if (ph_done) state_n = W_HI;
      W_HI:  if (ph_done) state_n = A_LO;
      A_LO:  if (ph_done) state_n = A_HI;
      A_HI:  if (ph_done) state_n = last_q ? FIN : WAIT;
      FIN:   if (ph_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Pin levels are registered from the next state so they line up with the state register.
  always_ff @(posedge SysClock or negedge Reset) begin
    if (!Reset) begin
      Mode        <= 1'b0;
      ClockIn     <= KEY_IDLE;
      ClearAddGen <= KEY_IDLE;
      RW          <= KEY_IDLE;
      CpuReset    <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      Mode        <= !(state_n inside {IDLE, FIN});
      ClockIn     <= (state_n == W_LO || state_n == A_LO) ? ~KEY_IDLE : KEY_IDLE;
      ClearAddGen <= (state_n == CLEAR) ? ~KEY_IDLE : KEY_IDLE;
      RW          <= (state_n == W_LO || state_n == W_HI) ? ~KEY_IDLE : KEY_IDLE;
      CpuReset    <= (state_n != IDLE);
      Busy        <= (state_n != IDLE);
    end
  end

  always_ff @(posedge SysClock or negedge Reset) begin
    if (!Reset) begin
      DataIn   <= '0;
      last_q   <= 1'b0;
      Count    <= '0;
      Done     <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      if (state == IDLE && Start) begin
        Done     <= 1'b0;
        Overflow <= 1'b0;
        Count    <= '0;
      end
      if (hs && !full) begin
        DataIn <= prog.s_data;
        last_q <= prog.s_last;
      end
      if (hs && full)             Overflow <= 1'b1;
      if (state == A_HI && ph_done) Count  <= Count + 5'd1;
      if (state == FIN && ph_done)  Done   <= 1'b1;
    end
  end
endmodule

// File: tb/tb_trisc_prog_loader.sv
// tb/tb_trisc_prog_loader.sv - randomized and directed bench for trisc_prog_loader against a RAM-level model
module tb_trisc_prog_loader;
  localparam int DEPTH   = 16;
  localparam int PULSE_W = 4;
  localparam int RST_W   = 2;

  logic       clk   = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic       Mode, ClockIn, ClearAddGen, RW, CpuReset, Busy, Done, Overflow;
  logic [7:0] DataIn;
  logic [4:0] Count;

  int errors = 0;
  int checks = 0;

  trisc_prog_loader_if #(.DATA_W(8)) bus ();

  trisc_prog_loader #(.DATA_W(8), .DEPTH(DEPTH), .PULSE_W(PULSE_W), .RST_W(RST_W)) dut (
    .SysClock    (clk),
    .Reset       (Reset),
    .Start       (Start),
    .prog        (bus),
    .Mode        (Mode),
    .ClockIn     (ClockIn),
    .ClearAddGen (ClearAddGen),
    .RW          (RW),
    .DataIn      (DataIn),
    .CpuReset    (CpuReset),
    .Busy        (Busy),
    .Done        (Done),
    .Overflow    (Overflow),
    .Count       (Count)
  );

  always #5 clk = ~clk;

  // RAM + address generator model: a rising ClockIn writes when RW=0, otherwise advances the address.
  logic [7:0] ram_m [DEPTH];
  logic [7:0] wr_q [$];
  logic [3:0] addr_m  = 4'd0;
  logic       prev_ci = 1'b1;
  int         pulses  = 0;

  always @(posedge clk) begin
    if (ClearAddGen === 1'b0) addr_m = 4'd0;
    if (prev_ci === 1'b0 && ClockIn === 1'b1) begin
      if (RW === 1'b0) begin
        ram_m[addr_m] = DataIn;
        wr_q.push_back(DataIn);
      end else begin
        addr_m = addr_m + 4'd1;
      end
    end
    if (prev_ci === 1'b1 && ClockIn === 1'b0) pulses++;
    prev_ci = ClockIn;
  end

  logic [7:0] prog_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_load();
    @(negedge clk);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last, input int stall,
                           input bit meas, output int gap);
    int n = 0;
    gap = 0;
    repeat (stall) @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    while (bus.s_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("hs_timeout", 32'(n < 200), 32'd1);
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    if (meas && !last) begin
      while (bus.s_ready !== 1'b1 && gap < 100) begin
        gap++;
        @(negedge clk);
      end
    end
  endtask

  task automatic wait_done(input string tag);
    int t  = 0;
    int tm = -1;
    int tr = -1;
    while (Done !== 1'b1 && t < 2000) begin
      if (tm < 0 && Mode === 1'b0)     tm = t;
      if (tr < 0 && CpuReset === 1'b0) tr = t;
      @(negedge clk);
      t++;
    end
    if (tm < 0 && Mode === 1'b0)     tm = t;
    if (tr < 0 && CpuReset === 1'b0) tr = t;
    check({tag, "_done_timeout"}, 32'(t < 2000), 32'd1);
    check({tag, "_cpureset_hold"}, 32'(tr - tm), 32'(RST_W));
  endtask

  task automatic run_load(input bit stall20, input bit poke, input string tag);
    int n, base, p0, exp_n, gap;
    n    = prog_q.size();
    base = wr_q.size();
    p0   = pulses;
    start_load();
    check({tag, "_start_flags"}, 32'({Busy, Mode, CpuReset, ClearAddGen, Done, Overflow}), 32'b111000);
    check({tag, "_start_count"}, 32'(Count), 32'd0);
    for (int i = 0; i < n; i++) begin
      if (stall20) begin
        repeat (20) @(negedge clk);
        check({tag, "_stall_count"}, 32'(Count), 32'(i));
        check({tag, "_stall_clockin"}, 32'(ClockIn), 32'd1);
        check({tag, "_stall_pulses"}, 32'(pulses - p0), 32'(2 * i));
      end
      send_byte(prog_q[i], i == n - 1, stall20 ? 0 : int'($urandom_range(0, 3)), 1'b1, gap);
      if (i < n - 1 && i < DEPTH) check({tag, "_gap"}, 32'(gap), 32'(4 * PULSE_W));
      if (poke && i == 1) begin
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
      end
    end
    wait_done(tag);
    exp_n = (n < DEPTH) ? n : DEPTH;
    check({tag, "_count"}, 32'(Count), 32'(exp_n));
    check({tag, "_overflow"}, 32'(Overflow), 32'(n > DEPTH));
    check({tag, "_end_flags"}, 32'({Done, Mode, Busy, CpuReset}), 32'b1000);
    check({tag, "_writes"}, 32'(wr_q.size() - base), 32'(exp_n));
    check({tag, "_pulses"}, 32'(pulses - p0), 32'(2 * exp_n));
    for (int i = 0; i < exp_n; i++) begin
      check({tag, "_wdata"}, 32'(wr_q[base + i]), 32'(prog_q[i]));
      check({tag, "_ram"}, 32'(ram_m[i]), 32'(prog_q[i]));
    end
  endtask

  initial begin
    int n, gap;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pins", 32'({Mode, ClockIn, ClearAddGen, RW, CpuReset, bus.s_ready}), 32'b011100);
    check("reset_status", 32'({Busy, Done, Overflow, Count, DataIn}), 32'd0);
    Reset = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 32'({Busy, Mode, bus.s_ready}), 32'd0);

    prog_q = {8'h1A, 8'h2B, 8'hF0};
    run_load(1'b0, 1'b0, "three");

    prog_q = {8'h5C, 8'hA3, 8'h07};
    run_load(1'b1, 1'b0, "stall");

    prog_q.delete();
    for (int i = 0; i < 17; i++) prog_q.push_back(8'($urandom_range(0, 255)));
    run_load(1'b0, 1'b0, "ovf17");
    check("ovf17_ram0", 32'(ram_m[0]), 32'(prog_q[0]));

    for (int r = 0; r < 3; r++) begin
      prog_q.delete();
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) prog_q.push_back(8'($urandom_range(0, 255)));
      run_load(1'b0, 1'b0, "rand");
    end

    prog_q.delete();
    for (int i = 0; i < 5; i++) prog_q.push_back(8'($urandom_range(0, 255)));
    run_load(1'b0, 1'b1, "busy_start");

    prog_q = {8'h11, 8'h22, 8'h33};
    start_load();
    send_byte(prog_q[0], 1'b0, 0, 1'b0, gap);
    send_byte(prog_q[1], 1'b0, 0, 1'b0, gap);
    check("midload_clockin_low", 32'(ClockIn), 32'd0);
    Reset = 1'b0;
    #1;
    check("midload_reset_pins", 32'({ClockIn, RW, Mode, Busy, CpuReset}), 32'b11000);
    @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    check("midload_reset_count", 32'({Count, Done}), 32'd0);

    prog_q.delete();
    for (int i = 0; i < 4; i++) prog_q.push_back(8'($urandom_range(0, 255)));
    run_load(1'b0, 1'b0, "recover");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
